// File: rtl/agex_muldiv_unit.sv
// agex_muldiv_unit: iterative RV32M multiply/divide unit for the AGEX stage.
// One op in flight. Multiply retires MUL_BITS_PER_C multiplier bits per cycle
// (shift-add). Divide is restoring, one quotient bit per cycle. Divide-by-zero
// and signed overflow bypass the iteration through a one-cycle SPEC state.
module agex_muldiv_unit #(
  parameter int DBITS          = 32,
  parameter int MUL_BITS_PER_C = 2,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [DBITS-1:0] in_a,
  input  logic [DBITS-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int K      = MUL_BITS_PER_C;
  localparam int MSTEPS = DBITS / K;
  localparam int CW     = $clog2(DBITS) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SPEC, S_DONE} state_t;

  // Per-op context latched on accept.
  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             neg;   // product / quotient sign
    logic             rneg;  // remainder sign (sign of a)
  } ctx_t;

  state_t             state_q, state_d;
  ctx_t               ctx_q, ctx_d;
  logic [2*DBITS-1:0] acc_q, acc_d;   // {hi, lo}: product, or {rem, quotient}
  logic [DBITS-1:0]   m_q, m_d;       // multiplicand magnitude, or divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DBITS-1:0]   res_q, res_d;

  // Accept-time operand decode.
  logic             is_div, sgn_a, sgn_b, sa, sb, div_zero, div_ovf;
  logic [DBITS-1:0] ma, mb;

  // Iteration datapath.
  logic [DBITS+K-1:0] mul_sum;
  logic [2*DBITS-1:0] mul_nxt, mul_fix;
  logic [DBITS:0]     div_sh, div_diff;
  logic               qbit;
  logic [2*DBITS-1:0] div_nxt;
  logic [DBITS-1:0]   quo_fix, rem_fix;

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = res_q;
  assign out_tag    = ctx_q.tag;

  // Operand signedness, magnitudes and special-case detection for the incoming op.
  always_comb begin
    is_div   = in_op[2];
    sgn_a    = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
    sgn_b    = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    sa       = sgn_a && in_a[DBITS-1];
    sb       = sgn_b && in_b[DBITS-1];
    ma       = sa ? (~in_a + 1'b1) : in_a;
    mb       = sb ? (~in_b + 1'b1) : in_b;
    div_zero = is_div && (in_b == '0);
    div_ovf  = is_div && !in_op[0] && (in_a == {1'b1, {(DBITS-1){1'b0}}}) && (in_b == '1);
  end

  // One multiply step and one divide step, plus the sign-corrected final results.
  always_comb begin
    mul_sum  = {{K{1'b0}}, acc_q[2*DBITS-1:DBITS]}
             + ((DBITS+K)'(m_q) * (DBITS+K)'(acc_q[K-1:0]));
    mul_nxt  = {mul_sum, acc_q[DBITS-1:K]};
    mul_fix  = ctx_q.neg ? (~mul_nxt + 1'b1) : mul_nxt;

    div_sh   = {acc_q[2*DBITS-1:DBITS], acc_q[DBITS-1]};
    div_diff = div_sh - {1'b0, m_q};
    qbit     = !div_diff[DBITS];
    div_nxt  = {(qbit ? div_diff[DBITS-1:0] : div_sh[DBITS-1:0]), acc_q[DBITS-2:0], qbit};
    quo_fix  = ctx_q.neg  ? (~div_nxt[DBITS-1:0] + 1'b1) : div_nxt[DBITS-1:0];
    rem_fix  = ctx_q.rneg ? (~div_nxt[2*DBITS-1:DBITS] + 1'b1) : div_nxt[2*DBITS-1:DBITS];
  end

  // Next-state / datapath control; flush overrides everything but reset.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    acc_d   = acc_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          ctx_d.op   = in_op;
          ctx_d.tag  = in_tag;
          ctx_d.neg  = sa ^ sb;
          ctx_d.rneg = sa;
          cnt_d      = '0;
          if (div_zero) begin
            res_d   = in_op[1] ? in_a : '1;
            state_d = S_SPEC;
          end else if (div_ovf) begin
            res_d   = in_op[1] ? '0 : in_a;
            state_d = S_SPEC;
          end else if (is_div) begin
            m_d     = mb;
            acc_d   = {{DBITS{1'b0}}, ma};
            state_d = S_DIV;
          end else begin
            m_d     = ma;
            acc_d   = {{DBITS{1'b0}}, mb};
            state_d = S_MUL;
          end
        end
        S_MUL: begin
          acc_d = mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(MSTEPS-1)) begin
            res_d   = (ctx_q.op == 3'd0) ? mul_fix[DBITS-1:0] : mul_fix[2*DBITS-1:DBITS];
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          acc_d = div_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DBITS-1)) begin
            res_d   = ctx_q.op[1] ? rem_fix : quo_fix;
            state_d = S_DONE;
          end
        end
        S_SPEC: state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears everything including accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ctx_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// Scoreboard bench for agex_muldiv_unit: stimulus pushes expected results,
// a negedge monitor checks latency on first out_valid and data on handoff.
module tb_agex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  agex_muldiv_unit #(.DBITS(32), .MUL_BITS_PER_C(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   seen  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first out_valid, result/tag on the handoff cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (!out_valid) seen = 0;
      if (out_valid && !seen) begin
        seen = 1;
        if (q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        else chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        chk("result", 64'(out_result), 64'(q[0].res));
        chk("tag", 64'(out_tag), 64'(q[0].tag));
        void'(q.pop_front());
        seen = 0;
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, optionally record the expectation.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push, input logic [31:0] res,
                       input int lat);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    if (ok && push) q.push_back('{res: res, tag: tag, lat: lat, acc: cyc});
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1 reset = 1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Multiplies
    issue(3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  1, 32'hFFFFFFEB, 16);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  1, 32'hFFFFFFFE, 16);
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd5,  1, 32'h40000000, 16);
    issue(3'd2, 32'hFFFFFFFF, 32'd2,        5'd6,  1, 32'hFFFFFFFF, 16);
    // Special-case divides
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7,  1, 32'h80000000, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd8,  1, 32'h00000000, 1);
    issue(3'd5, 32'd13,       32'd0,        5'd9,  1, 32'hFFFFFFFF, 1);
    issue(3'd7, 32'd13,       32'd0,        5'd10, 1, 32'd13,       1);
    issue(3'd4, 32'hFFFFFFFB, 32'd0,        5'd11, 1, 32'hFFFFFFFF, 1);
    issue(3'd6, 32'hFFFFFFFB, 32'd0,        5'd12, 1, 32'hFFFFFFFB, 1);
    // Iterative divides
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        5'd13, 1, 32'hFFFFFFFD, 32);
    issue(3'd6, 32'hFFFFFFF9, 32'd2,        5'd14, 1, 32'hFFFFFFFF, 32);
    issue(3'd5, 32'd100,      32'd7,        5'd15, 1, 32'd14,       32);
    issue(3'd7, 32'd100,      32'd7,        5'd16, 1, 32'd2,        32);
    drain();

    // Output hold under back-pressure
    out_ready = 0;
    issue(3'd0, 32'd6, 32'd9, 5'd20, 1, 32'd54, 16);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(out_result), 64'd54);
      chk("hold_tag", 64'(out_tag), 64'd20);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("release_idle", 64'(busy), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_queue", 64'(q.size()), 64'd0);

    // Flush at DIV step 10
    issue(3'd5, 32'd1000, 32'd3, 5'd21, 0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    repeat (40) @(posedge clk);
    issue(3'd0, 32'd12345, 32'd1000, 5'd22, 1, 32'd12345000, 16);
    drain();

    // in_valid together with flush is not accepted
    @(posedge clk); #1;
    in_valid = 1; in_op = 3'd0; in_a = 32'd1; in_b = 32'd1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_same_cycle_busy", 64'(busy), 64'd0);

    // Reset mid-MUL
    issue(3'd0, 32'd3, 32'd5, 5'd23, 0, 32'd0, 0);
    repeat (5) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1 reset = 1;
    repeat (30) @(posedge clk);
    #1 chk("post_rst_busy", 64'(busy), 64'd0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 1, 32'h00000000, 16);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
